// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache memory arbiter; round-robin tie-break when MEM_ARB_ROUND_ROBIN_EN is defined
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              i_req;
  logic              d_req;
  logic              pick_d;
  logic              cap_read;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;

  // On a tie D wins only when I was the last one served
  assign pick_d = d_req & (~i_req | ~last_d);

  // Remember who was granted last; starts as D so I wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b1;
    end else if (state == IDLE && (i_req | d_req)) begin
      last_d <= pick_d;
    end
  end
`else
  // Fixed priority: D wins every tie
  assign pick_d = d_req;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          state_nxt = pick_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's request; read+write together becomes a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_read  <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && (i_req | d_req)) begin
      if (pick_d) begin
        cap_read  <= d_read & ~d_write;
        cap_write <= d_write;
        cap_addr  <= d_addr;
        cap_wdata <= d_wdata;
      end else begin
        cap_read  <= i_read & ~i_write;
        cap_write <= i_write;
        cap_addr  <= i_addr;
        cap_wdata <= i_wdata;
      end
    end
  end

  // Latch read data for the owner on a completed read only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (mem_ready && cap_read) begin
      if (state == BUSY_I) begin
        i_rdata_q <= mem_rdata;
      end
      if (state == BUSY_D) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;

  // Strobes, readies and grant decoded from state; nothing leaks out in IDLE/DONE
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    grant     = 2'b00;
    case (state)
      BUSY_I: begin
        grant     = 2'b01;
        mem_read  = cap_read;
        mem_write = cap_write;
        i_ready   = mem_ready;
      end
      BUSY_D: begin
        grant     = 2'b10;
        mem_read  = cap_read;
        mem_write = cap_write;
        d_ready   = mem_ready;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

endmodule
